// File: rtl/vram_bc_pkg.sv
// Shared types and sizes for the VRAM B/C port-A arbiter.
package vram_bc_pkg;

  localparam int unsigned VRAM_AW = 14;
  localparam int unsigned VRAM_DW = 32;
  localparam int unsigned VRAM_BW = VRAM_DW / 8;

  typedef enum logic [1:0] {
    ARB,
    DRAIN,
    LOCKED
  } arb_state_t;

  typedef enum logic [1:0] {
    ID_GPU,
    ID_CPU,
    ID_SS
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/vram_bc_tag_pipe.sv
// MEM_LAT-deep shift register carrying read tags alongside the array latency.
module vram_bc_tag_pipe
  import vram_bc_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic    clock,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out,
  output logic    empty
);

  rd_tag_t stage [MEM_LAT];

  // Shift tags one stage per cycle; reset discards everything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < MEM_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < MEM_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[MEM_LAT-1];

  // Empty means nothing will still be in flight after this cycle: the final
  // stage is delivering its data right now, so it does not block a drain.
  always_comb begin
    empty = 1'b1;
    for (int unsigned i = 0; i + 1 < MEM_LAT; i++) begin
      if (stage[i].valid) empty = 1'b0;
    end
  end

endmodule

// File: rtl/vram_bc_arbiter.sv
// Port-A arbiter for the 16K x 32 VRAM B/C array: GPU > CPU > savestate,
// CPU anti-starvation, savestate exclusive lock with drain.
// Optional macro VRAM_BC_ARB_PERF_EN adds saturating GPU/CPU stall counters.
module vram_bc_arbiter
  import vram_bc_pkg::*;
#(
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned CPU_MAXW = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               gpu_req,
  input  logic [VRAM_AW-1:0] gpu_addr,
  output logic               gpu_ack,
  output logic               gpu_rvalid,
  output logic [VRAM_DW-1:0] gpu_rdata,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [VRAM_DW-1:0] cpu_wdata,
  input  logic [VRAM_BW-1:0] cpu_be,
  output logic               cpu_ack,
  output logic               cpu_rvalid,
  output logic [VRAM_DW-1:0] cpu_rdata,
  input  logic               ss_lock,
  output logic               ss_locked,
  input  logic               ss_req,
  input  logic               ss_we,
  input  logic [VRAM_AW-1:0] ss_addr,
  input  logic [VRAM_DW-1:0] ss_wdata,
  output logic               ss_ack,
  output logic               ss_rvalid,
  output logic [VRAM_DW-1:0] ss_rdata,
  output logic [VRAM_AW-1:0] mem_addr,
  output logic               mem_wren,
  output logic [VRAM_DW-1:0] mem_data,
  output logic [VRAM_BW-1:0] mem_be,
  input  logic [VRAM_DW-1:0] mem_q
`ifdef VRAM_BC_ARB_PERF_EN
  ,
  output logic [15:0]        perf_gpu_stall,
  output logic [15:0]        perf_cpu_stall
`endif
);

  localparam logic [7:0] MAXW = 8'(CPU_MAXW);

  arb_state_t         state, state_nx;
  logic [7:0]         cpu_wait;
  logic               grant_gpu, grant_cpu, grant_ss;
  logic               cpu_force;
  logic               issue;
  logic [VRAM_AW-1:0] last_addr;
  rd_tag_t            tag_in, tag_out;
  logic               pipe_empty;
  logic               ret_valid;
  logic [VRAM_DW-1:0] gpu_hold, cpu_hold, ss_hold;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ARB;
    else       state <= state_nx;
  end

  // Next state and grant selection; at most one grant per cycle.
  always_comb begin
    state_nx  = state;
    grant_gpu = 1'b0;
    grant_cpu = 1'b0;
    grant_ss  = 1'b0;
    cpu_force = cpu_req && (cpu_wait == MAXW);
    unique case (state)
      ARB: begin
        if (ss_lock)        state_nx  = DRAIN;
        else if (cpu_force) grant_cpu = 1'b1;
        else if (gpu_req)   grant_gpu = 1'b1;
        else if (cpu_req)   grant_cpu = 1'b1;
        else if (ss_req)    grant_ss  = 1'b1;
      end
      DRAIN: begin
        if (!ss_lock)        state_nx = ARB;
        else if (pipe_empty) state_nx = LOCKED;
      end
      LOCKED: begin
        grant_ss = ss_req;
        if (!ss_lock) state_nx = ARB;
      end
      default: state_nx = ARB;
    endcase
    if (reset) begin
      grant_gpu = 1'b0;
      grant_cpu = 1'b0;
      grant_ss  = 1'b0;
    end
  end

  assign gpu_ack   = grant_gpu;
  assign cpu_ack   = grant_cpu;
  assign ss_ack    = grant_ss;
  assign ss_locked = (state == LOCKED) && !reset;

  // Drive the array from the winner; idle cycles keep the last address.
  always_comb begin
    issue    = grant_gpu | grant_cpu | grant_ss;
    mem_addr = last_addr;
    mem_wren = 1'b0;
    mem_data = '0;
    mem_be   = '0;
    tag_in   = '0;
    if (grant_gpu) begin
      mem_addr = gpu_addr;
      tag_in   = '{valid: 1'b1, id: ID_GPU};
    end else if (grant_cpu) begin
      mem_addr = cpu_addr;
      mem_wren = cpu_we;
      mem_data = cpu_wdata;
      mem_be   = cpu_we ? cpu_be : '0;
      tag_in   = '{valid: !cpu_we, id: ID_CPU};
    end else if (grant_ss) begin
      mem_addr = ss_addr;
      mem_wren = ss_we;
      mem_data = ss_wdata;
      mem_be   = ss_we ? '1 : '0;
      tag_in   = '{valid: !ss_we, id: ID_SS};
    end
  end

  // Remember the last issued address so idle cycles do not toggle address_a.
  always_ff @(posedge clock) begin
    if (reset)      last_addr <= '0;
    else if (issue) last_addr <= mem_addr;
  end

  // CPU anti-starvation: count unserved cycles, frozen while savestate owns the port.
  always_ff @(posedge clock) begin
    if (reset)                      cpu_wait <= '0;
    else if (state == LOCKED)       cpu_wait <= cpu_wait;
    else if (!cpu_req || grant_cpu) cpu_wait <= '0;
    else if (cpu_wait != MAXW)      cpu_wait <= cpu_wait + 8'd1;
  end

  vram_bc_tag_pipe #(
    .MEM_LAT(MEM_LAT)
  ) u_tag_pipe (
    .clock  (clock),
    .reset  (reset),
    .tag_in (tag_in),
    .tag_out(tag_out),
    .empty  (pipe_empty)
  );

  assign ret_valid  = tag_out.valid && !reset;
  assign gpu_rvalid = ret_valid && (tag_out.id == ID_GPU);
  assign cpu_rvalid = ret_valid && (tag_out.id == ID_CPU);
  assign ss_rvalid  = ret_valid && (tag_out.id == ID_SS);

  // Hold each requester's last read word between returns.
  always_ff @(posedge clock) begin
    if (reset) begin
      gpu_hold <= '0;
      cpu_hold <= '0;
      ss_hold  <= '0;
    end else begin
      if (gpu_rvalid) gpu_hold <= mem_q;
      if (cpu_rvalid) cpu_hold <= mem_q;
      if (ss_rvalid)  ss_hold  <= mem_q;
    end
  end

  assign gpu_rdata = gpu_rvalid ? mem_q : gpu_hold;
  assign cpu_rdata = cpu_rvalid ? mem_q : cpu_hold;
  assign ss_rdata  = ss_rvalid  ? mem_q : ss_hold;

`ifdef VRAM_BC_ARB_PERF_EN
  // Saturating stall counters: cycles a request is held without an ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_gpu_stall <= '0;
      perf_cpu_stall <= '0;
    end else begin
      if (gpu_req && !grant_gpu && (perf_gpu_stall != '1))
        perf_gpu_stall <= perf_gpu_stall + 16'd1;
      if (cpu_req && !grant_cpu && (perf_cpu_stall != '1))
        perf_cpu_stall <= perf_cpu_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_bc_arbiter.sv
// Directed bench for vram_bc_arbiter with a VRAM array model and a
// per-requester read scoreboard.
module tb_vram_bc_arbiter;

  localparam int unsigned LAT  = 2;
  localparam int unsigned MAXW = 8;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  typedef struct {
    logic        gpu_ack, cpu_ack, ss_ack;
    logic        gpu_rv, cpu_rv, ss_rv;
    logic        ss_locked, mem_wren;
    logic [13:0] mem_addr;
    logic [31:0] mem_data, gpu_rdata, cpu_rdata, ss_rdata;
    logic [3:0]  mem_be;
`ifdef VRAM_BC_ARB_PERF_EN
    logic [15:0] pg, pc;
`endif
  } snap_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, mem_init;
  logic        gpu_req, gpu_ack, gpu_rvalid;
  logic [13:0] gpu_addr;
  logic [31:0] gpu_rdata;
  logic        cpu_req, cpu_we, cpu_ack, cpu_rvalid;
  logic [13:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_be;
  logic        ss_lock, ss_locked, ss_req, ss_we, ss_ack, ss_rvalid;
  logic [13:0] ss_addr;
  logic [31:0] ss_wdata, ss_rdata;
  logic [13:0] mem_addr;
  logic        mem_wren;
  logic [31:0] mem_data, mem_q;
  logic [3:0]  mem_be;
`ifdef VRAM_BC_ARB_PERF_EN
  logic [15:0] perf_gpu_stall, perf_cpu_stall;
`endif

  vram_bc_arbiter #(
    .MEM_LAT (LAT),
    .CPU_MAXW(MAXW)
  ) dut (
    .clock(clock), .reset(reset),
    .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_ack(gpu_ack),
    .gpu_rvalid(gpu_rvalid), .gpu_rdata(gpu_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ss_lock(ss_lock), .ss_locked(ss_locked),
    .ss_req(ss_req), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdata(ss_wdata),
    .ss_ack(ss_ack), .ss_rvalid(ss_rvalid), .ss_rdata(ss_rdata),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_data(mem_data),
    .mem_be(mem_be), .mem_q(mem_q)
`ifdef VRAM_BC_ARB_PERF_EN
    , .perf_gpu_stall(perf_gpu_stall), .perf_cpu_stall(perf_cpu_stall)
`endif
  );

  function automatic logic [31:0] pat(logic [13:0] a);
    return {2'b10, a, 2'b01, ~a};
  endfunction

  // Array model: registered address, LAT cycles to q, byte-enabled writes.
  logic [31:0] vram   [16384];
  logic [31:0] q_pipe [LAT];
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 16384; i++) vram[i] <= pat(14'(i));
    end else if (mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) vram[mem_addr][b*8 +: 8] <= mem_data[b*8 +: 8];
    end
    q_pipe[0] <= vram[mem_addr];
    for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_q = q_pipe[LAT-1];

  logic [31:0] shadow [16384];
  exp_t        sb [3][$];
  string       nm [3] = '{"gpu", "cpu", "ss"};
  snap_t       s;
  int unsigned cyc = 0;
  int unsigned rv_seen = 0;
  int unsigned n_assert = 0;
  int unsigned n_fail = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_shadow(logic [13:0] a, logic [31:0] d, logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // One clock: sample at negedge, score returns, record accepted requests.
  task automatic cycle();
    exp_t        e;
    logic        rv [3];
    logic [31:0] rd [3];
    @(negedge clock);
    s.gpu_ack = gpu_ack; s.cpu_ack = cpu_ack; s.ss_ack = ss_ack;
    s.gpu_rv = gpu_rvalid; s.cpu_rv = cpu_rvalid; s.ss_rv = ss_rvalid;
    s.ss_locked = ss_locked; s.mem_wren = mem_wren; s.mem_addr = mem_addr;
    s.mem_data = mem_data; s.mem_be = mem_be;
    s.gpu_rdata = gpu_rdata; s.cpu_rdata = cpu_rdata; s.ss_rdata = ss_rdata;
`ifdef VRAM_BC_ARB_PERF_EN
    s.pg = perf_gpu_stall; s.pc = perf_cpu_stall;
`endif
    rv = '{gpu_rvalid, cpu_rvalid, ss_rvalid};
    rd = '{gpu_rdata, cpu_rdata, ss_rdata};
    for (int i = 0; i < 3; i++) begin
      if (rv[i]) begin
        rv_seen++;
        if (sb[i].size() == 0) begin
          check({nm[i], " unexpected rvalid"}, 32'd1, 32'd0);
        end else begin
          e = sb[i].pop_front();
          check({nm[i], " rdata"}, rd[i], e.data);
          check({nm[i], " rvalid cycle"}, cyc, e.due);
        end
      end
    end
    if (gpu_ack) sb[0].push_back('{data: shadow[gpu_addr], due: cyc + LAT});
    if (cpu_ack) begin
      if (cpu_we) wr_shadow(cpu_addr, cpu_wdata, cpu_be);
      else        sb[1].push_back('{data: shadow[cpu_addr], due: cyc + LAT});
    end
    if (ss_ack) begin
      if (ss_we) wr_shadow(ss_addr, ss_wdata, 4'hF);
      else       sb[2].push_back('{data: shadow[ss_addr], due: cyc + LAT});
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(int unsigned n);
    for (int unsigned k = 0; k < n; k++) cycle();
  endtask

  logic [31:0] expw;
  int unsigned rv_before;

  initial begin
    for (int i = 0; i < 16384; i++) shadow[i] = pat(14'(i));
    reset = 1'b1; mem_init = 1'b1;
    gpu_req = 0; gpu_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    ss_lock = 0; ss_req = 0; ss_we = 0; ss_addr = '0; ss_wdata = '0;
    cycle();
    mem_init = 1'b0;
    idle(2);
    reset = 1'b0;
    cycle();
    check("reset gpu_ack", s.gpu_ack, 0);
    check("reset cpu_ack", s.cpu_ack, 0);
    check("reset ss_ack", s.ss_ack, 0);
    check("reset ss_locked", s.ss_locked, 0);
    check("reset rvalids", {s.gpu_rv, s.cpu_rv, s.ss_rv}, 0);
    check("reset mem_addr", s.mem_addr, 0);
    check("reset mem_wren", s.mem_wren, 0);
    check("reset gpu_rdata", s.gpu_rdata, 0);

    // GPU streaming reads, CPU idle.
    gpu_req = 1; gpu_addr = 14'h0010;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("gpu stream ack", s.gpu_ack, 1);
    end
    gpu_req = 0;
    idle(LAT + 1);
    check("gpu stream drained", sb[0].size(), 0);

    // CPU partial write then read back.
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0100; cpu_wdata = 32'h0000_1234; cpu_be = 4'b0011;
    cycle();
    check("cpu wr ack", s.cpu_ack, 1);
    check("cpu wr wren", s.mem_wren, 1);
    check("cpu wr be", s.mem_be, 4'b0011);
    cpu_we = 0;
    cycle();
    check("cpu rd ack", s.cpu_ack, 1);
    check("cpu rd wren", s.mem_wren, 0);
    cpu_req = 0;
    idle(LAT + 1);
    expw = pat(14'h0100);
    expw[15:0] = 16'h1234;
    check("cpu rdata held", s.cpu_rdata, expw);
    check("idle mem_addr holds", s.mem_addr, 14'h0100);
    check("idle mem_wren", s.mem_wren, 0);

    // GPU + CPU + SS all held: GPU wins until the CPU starvation limit.
    gpu_req = 1; gpu_addr = 14'h0020;
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0200;
    ss_req = 1; ss_we = 0; ss_addr = 14'h3000;
    for (int k = 1; k <= 9; k++) begin
      cycle();
      check($sformatf("starve gpu_ack c%0d", k), s.gpu_ack, (k < 9) ? 1 : 0);
      check($sformatf("starve cpu_ack c%0d", k), s.cpu_ack, (k == 9) ? 1 : 0);
      check($sformatf("starve ss_ack c%0d", k), s.ss_ack, 0);
    end
    cpu_addr = 14'h0201;
    cycle();
    check("gpu resumes", s.gpu_ack, 1);
    check("cpu waits again", s.cpu_ack, 0);
    gpu_req = 0; cpu_req = 0;
    cycle();
    check("ss lowest prio ack", s.ss_ack, 1);
    ss_req = 0;
    idle(LAT + 1);

    // Savestate lock with a GPU read in flight.
    gpu_req = 1; gpu_addr = 14'h0030;
    cycle();
    check("lock pre gpu_ack", s.gpu_ack, 1);
    ss_lock = 1;
    cycle();
    check("lock arb gpu stall", s.gpu_ack, 0);
    check("lock arb not locked", s.ss_locked, 0);
    cycle();
    check("drain gpu_rvalid", s.gpu_rv, 1);
    check("drain gpu stall", s.gpu_ack, 0);
    check("drain not locked", s.ss_locked, 0);
    cycle();
    check("locked", s.ss_locked, 1);
    check("locked gpu stall", s.gpu_ack, 0);
    ss_req = 1; ss_we = 1; ss_addr = 14'h3FFF; ss_wdata = 32'hCAFE_F00D;
    cycle();
    check("ss wr ack", s.ss_ack, 1);
    check("ss wr wren", s.mem_wren, 1);
    check("ss wr addr", s.mem_addr, 14'h3FFF);
    check("ss wr data", s.mem_data, 32'hCAFE_F00D);
    ss_we = 0;
    cycle();
    check("ss rd ack", s.ss_ack, 1);
    ss_req = 0; ss_lock = 0;
    cycle();
    check("unlock cycle gpu stall", s.gpu_ack, 0);
    check("unlock cycle still locked", s.ss_locked, 1);
    cycle();
    check("gpu after unlock", s.gpu_ack, 1);
    check("unlocked", s.ss_locked, 0);
    check("ss rdata", s.ss_rdata, 32'hCAFE_F00D);
    gpu_req = 0;
    idle(LAT + 1);

    // Lock withdrawn during drain: back to normal arbitration.
    gpu_req = 1; gpu_addr = 14'h0050;
    cycle();
    gpu_req = 0; ss_lock = 1; ss_req = 1; ss_we = 0; ss_addr = 14'h2000;
    cycle();
    check("lock req blocks ss", s.ss_ack, 0);
    ss_lock = 0;
    cycle();
    check("drain abort no ss grant", s.ss_ack, 0);
    cycle();
    check("drain abort not locked", s.ss_locked, 0);
    check("drain abort ss arb ack", s.ss_ack, 1);
    ss_req = 0;
    idle(LAT + 1);

    // Reset with two reads in flight.
    gpu_req = 1; gpu_addr = 14'h0040;
    idle(2);
    gpu_req = 0; reset = 1;
    for (int i = 0; i < 3; i++) sb[i].delete();
    rv_before = rv_seen;
    cycle();
    reset = 0;
    idle(LAT + 2);
    check("no rvalid after reset", rv_seen - rv_before, 0);
    check("post reset gpu_rdata", s.gpu_rdata, 0);
    check("post reset ss_rdata", s.ss_rdata, 0);
    check("post reset mem_addr", s.mem_addr, 0);
    check("post reset ss_locked", s.ss_locked, 0);

`ifdef VRAM_BC_ARB_PERF_EN
    // CPU held behind GPU for five cycles.
    gpu_req = 1; gpu_addr = 14'h0060;
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0600;
    idle(5);
    gpu_req = 0; cpu_req = 0;
    cycle();
    check("perf_cpu_stall", s.pc, 5);
    check("perf_gpu_stall", s.pg, 0);
`endif

    idle(LAT + 2);
    check("gpu scoreboard empty", sb[0].size(), 0);
    check("cpu scoreboard empty", sb[1].size(), 0);
    check("ss scoreboard empty", sb[2].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
